muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Executes MULT, MULTU, DIV and DIVU and produces the HI/LO pair.
- Uses a valid/ready handshake on both input and output, so issue logic and the HI/LO write-back can stall independently.
- Generalises the HI/LO path to any data width, with a configurable multiplier latency and an iterative divider.

Parameters:
DATA_W, 32, operand/result width; must be even and ≥8
MUL_STAGES, 2, multiplier pipeline depth in cycles; ≥1

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept; high only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src0  in  DATA_W  multiplicand / dividend
src1  in  DATA_W  multiplier / divisor
flush  in  1  synchronous abort of any in-flight operation
out_valid  out  1  hi/lo hold a completed result
out_ready  in  1  consumer takes the result
hi  out  DATA_W  MUL: upper half of product; DIV: remainder
lo  out  DATA_W  MUL: lower half of product; DIV: quotient
busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, out_valid=0, hi=0, lo=0, busy=0, iteration counter=0.
  - in_ready = (state==IDLE), combinational; it reads 1 during reset, but no accept occurs while reset is high.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Accept: in_valid && in_ready at a rising edge; src0/src1/op are latched.
  - MULT/MULTU → MUL.
  - DIV/DIVU with src1≠0 → DIV.
  - DIV/DIVU with src1==0 → DONE directly.
- MUL:
  - Full 2·DATA_W product, signed (MULT) or unsigned (MULTU).
  - Stays MUL_STAGES cycles → DONE.
  - out_valid rises MUL_STAGES+1 edges after the accepting edge.
- DIV:
  - Restoring radix-2 division on operand magnitudes; unsigned for DIVU, |x| for DIV.
  - Exactly DATA_W iterations, counter DATA_W-1 down to 0, then → FIX.
- FIX (1 cycle):
  - DIV only: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - → DONE. out_valid rises DATA_W+2 edges after accept.
  - Signed overflow (MIN / -1): lo=MIN, hi=0, produced naturally by magnitude arithmetic with DATA_W-bit wrap.
- Divide by zero: hi=src0, lo=all ones; out_valid 1 edge after accept. No exception is raised.
- DONE:
  - out_valid=1; hi/lo stable.
  - Leaves to IDLE on the edge where out_ready=1; out_valid is 0 the next cycle.
  - While out_ready=0, hold indefinitely.
- hi/lo are updated only on entry to DONE and otherwise retain their last value, including after IDLE.
- flush:
  - In any state, the next state is IDLE and out_valid deasserts.
  - hi/lo are not updated by an aborted operation.
  - flush has priority over accept and over out_ready in the same cycle.
- No back-to-back overlap: a new accept is possible earliest the cycle after DONE exits.
- in_valid while not in_ready is ignored; the requester must hold it.

Optional Feature:
- Macro: MULDIV_DIV_EARLY_OUT_EN.
- Defined: on DIV/DIVU accept, if |divisor| > |dividend| (magnitudes as in DIV), go straight to DONE.
  - Result: lo=0, hi=src0 (dividend unchanged, sign preserved).
  - out_valid 1 edge after accept.
- Undefined: these cases take the full DATA_W+2 latency with identical results.
- Divide-by-zero handling is the same either way.

Test Plan:
- MULT src0=0xFFFFFFFE, src1=3, out_ready=1 → hi=0xFFFFFFFF, lo=0xFFFFFFFA; out_valid 3 edges after accept for 1 cycle. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF at 34 edges. DIVU 7/2 → lo=3, hi=1. DIV 7/-2 → lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 0x1234/0 → hi=0x1234, lo=0xFFFFFFFF, 1 edge.
- Backpressure: out_ready=0 for 5 cycles after completion → out_valid, hi, lo constant and in_ready=0; out_ready=1 → IDLE next edge, in_ready=1.
- Abort/reset:
  - flush at DIV iteration 10 → IDLE next edge, out_valid never rises, hi/lo unchanged.
  - reset asserted mid-MUL → outputs zero immediately without a clock edge.
- With MULDIV_DIV_EARLY_OUT_EN: DIVU 3/10 → lo=0, hi=3 at 1 edge. Without it → same values at 34 edges.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit producing a HI/LO result pair.
//
// Operations (op_i): 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
// Multiplies take MUL_STAGES cycles in StMul. Divides run a restoring radix-2
// loop over DATA_W cycles on operand magnitudes, then spend one cycle in StFix
// applying signs. Divide-by-zero completes immediately with hi=src0, lo=all ones.
//
// Optional feature, enabled by defining MULDIV_DIV_EARLY_OUT_EN:
//   When |divisor| > |dividend|, a divide completes immediately with lo=0 and
//   hi=src0. Results are identical either way; only the latency changes.
//
// Ports:
//   clk_i        clock
//   reset_i      asynchronous active-high reset
//   in_valid_i   operation request
//   in_ready_o   unit can accept (idle only)
//   op_i         operation select
//   src0_i       multiplicand / dividend
//   src1_i       multiplier / divisor
//   flush_i      synchronous abort of any in-flight operation
//   out_valid_o  hi_o/lo_o hold a completed result
//   out_ready_i  consumer takes the result
//   hi_o         MUL: upper product half; DIV: remainder
//   lo_o         MUL: lower product half; DIV: quotient
//   busy_o       unit is not idle
module muldiv_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] src0_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o
);

  localparam int unsigned CntMax = (DATA_W > MUL_STAGES) ? DATA_W : MUL_STAGES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  // a_q: multiplicand, or dividend magnitude shifting into the quotient.
  // b_q: multiplier, or divisor magnitude.
  logic [DATA_W-1:0]   a_q, b_q, rem_q;
  logic                mul_signed_q, neg_quo_q, neg_rem_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   hi_q, lo_q;

  logic                src_signed;
  logic [DATA_W-1:0]   abs0, abs1;
  logic [2*DATA_W-1:0] ext_a, ext_b, product;
  logic [DATA_W:0]     rem_sh, rem_sub;
  logic                sub_ok;

  always_comb begin
    src_signed = ~op_i[0];
    abs0 = (src_signed && src0_i[DATA_W-1]) ? -src0_i : src0_i;
    abs1 = (src_signed && src1_i[DATA_W-1]) ? -src1_i : src1_i;

    ext_a   = mul_signed_q ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
    ext_b   = mul_signed_q ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
    product = ext_a * ext_b;

    // Remainder stays below the divisor, so the W+1-bit difference is negative
    // exactly when the trial subtraction fails.
    rem_sh  = {rem_q, a_q[DATA_W-1]};
    rem_sub = rem_sh - {1'b0, b_q};
    sub_ok  = ~rem_sub[DATA_W];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rem_q        <= '0;
      mul_signed_q <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else if (flush_i) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            if (!op_i[1]) begin
              a_q          <= src0_i;
              b_q          <= src1_i;
              mul_signed_q <= src_signed;
              cnt_q        <= CntW'(MUL_STAGES - 1);
              state_q      <= StMul;
            end else if (src1_i == '0) begin
              hi_q        <= src0_i;
              lo_q        <= '1;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
`ifdef MULDIV_DIV_EARLY_OUT_EN
            end else if (abs1 > abs0) begin
              hi_q        <= src0_i;
              lo_q        <= '0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
`endif
            end else begin
              a_q       <= abs0;
              b_q       <= abs1;
              rem_q     <= '0;
              neg_quo_q <= src_signed && (src0_i[DATA_W-1] ^ src1_i[DATA_W-1]);
              neg_rem_q <= src_signed && src0_i[DATA_W-1];
              cnt_q     <= CntW'(DATA_W - 1);
              state_q   <= StDiv;
            end
          end
        end
        StMul: begin
          if (cnt_q == '0) begin
            hi_q        <= product[2*DATA_W-1:DATA_W];
            lo_q        <= product[DATA_W-1:0];
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDiv: begin
          a_q   <= {a_q[DATA_W-2:0], sub_ok};
          rem_q <= sub_ok ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StFix: begin
          lo_q        <= neg_quo_q ? -a_q : a_q;
          hi_q        <= neg_rem_q ? -rem_q : rem_q;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign out_valid_o = out_valid_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (DATA_W=32, MUL_STAGES=2): directed cases,
// backpressure, flush, async reset, then randomized operations against an
// arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  src0 = '0;
  logic [W-1:0]  src1 = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  hi, lo;
  logic          busy;

  int n_checks = 0;
  int n_bad    = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  muldiv_unit #(.DATA_W(W), .MUL_STAGES(2)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .src0_i      (src0),
    .src1_i      (src1),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .hi_o        (hi),
    .lo_o        (lo),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; latency counts the accepting edge as edge 1.
  task automatic model(input logic [1:0] mop, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output int lat);
    longint sa, sb, ma, mb;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (mop)
      2'b00: begin
        p = 64'(sa * sb);
        eh = p[63:32]; el = p[31:0]; lat = 3;
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        eh = p[63:32]; el = p[31:0]; lat = 3;
      end
      default: begin
        if (mop == 2'b11) begin
          ma = longint'({32'b0, a});
          mb = longint'({32'b0, b});
        end else begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
        end
        lat = 34;
        if (b == '0) begin
          eh = a; el = '1; lat = 1;
        end else if (mop == 2'b11) begin
          el = a / b; eh = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000; eh = '0;
        end else begin
          ia = $signed(a); ib = $signed(b);
          el = 32'(ia / ib); eh = 32'(ia % ib);
        end
`ifdef MULDIV_DIV_EARLY_OUT_EN
        if (b != '0 && mb > ma) lat = 1;
`endif
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] mop, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
    logic [W-1:0] eh, el;
    int lat, edges;
    model(mop, a, b, eh, el, lat);
    @(negedge clk);
    out_ready = (stall == 0);
    check_eq("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1; op = mop; src0 = a; src1 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    check_eq("latency", 64'(edges), 64'(lat));
    check_eq("hi", 64'(hi), 64'(eh));
    check_eq("lo", 64'(lo), 64'(el));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 64'(out_valid), 64'(1));
      check_eq("hold_hi", 64'(hi), 64'(eh));
      check_eq("hold_lo", 64'(lo), 64'(el));
      check_eq("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("valid_drop", 64'(out_valid), 64'(0));
    check_eq("in_ready_after", 64'(in_ready), 64'(1));
    last_hi = eh;
    last_lo = el;
  endtask

  initial begin
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    int seen;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(out_valid), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_hi", 64'(hi), 64'(0));
    check_eq("rst_lo", 64'(lo), 64'(0));
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b11, 32'd7, 32'd2, 0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b11, 32'h1234, 32'd0, 0);
    run_op(2'b11, 32'd3, 32'd10, 0);
    run_op(2'b10, 32'hFFFF_FFFD, 32'd10, 0);
    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5);

    // Flush mid-divide: no result, hi/lo retained
    @(negedge clk);
    in_valid = 1'b1; op = 2'b10; src0 = 32'd100; src1 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_busy", 64'(busy), 64'(0));
    check_eq("flush_in_ready", 64'(in_ready), 64'(1));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check_eq("flush_no_valid", 64'(seen), 64'(0));
    check_eq("flush_hi", 64'(hi), 64'(last_hi));
    check_eq("flush_lo", 64'(lo), 64'(last_lo));

    // Flush wins over a simultaneous accept
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 2'b00; src0 = 32'd5; src1 = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_eq("flush_prio_busy", 64'(busy), 64'(0));

    // Async reset mid-multiply
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; src0 = 32'd5; src1 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    check_eq("mul_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check_eq("arst_busy", 64'(busy), 64'(0));
    check_eq("arst_valid", 64'(out_valid), 64'(0));
    check_eq("arst_hi", 64'(hi), 64'(0));
    check_eq("arst_lo", 64'(lo), 64'(0));
    check_eq("arst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    reset = 1'b0;

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      run_op(rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
